// File: rtl/fetch_stage2_predecode.sv
// ---------------------------------------------------------------------------
// fetch_stage2_predecode
//
// Second fetch stage. It registers the 4-instruction bundle coming out of
// FetchStage1 together with the BTB/branch-predictor information for each
// slot. It then pre-decodes the held bundle to catch two kinds of problem:
// direct control transfers that the BTB missed, and BTB targets that do not
// match the decoded target. When it finds one, it raises a redirect back to
// FetchStage1. It also passes the bundle to decode with a per-slot valid mask.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   flush_i          squash stage contents (recovery / exception)
//   stall_i          decode is not accepting; hold every stage register
//   fs1Ready_i       FS1 bundle is valid this cycle
//   pc_i             FS1 bundle PC (slot n lives at pc_i + 8n)
//   bundle_i         four instructions, slot 0 in the LSBs
//   btbHit_i         per-slot BTB hit
//   btbTarget_i      per-slot BTB/RAS target, slot 0 in the LSBs
//   pred_i           per-slot direction prediction
//   rasTop_i         return-address-stack top from FS1
//   flagRecoverID_o  redirect FS1 (one pulse per held bundle)
//   targetAddrID_o   redirect target
//   flagCallID_o     redirecting slot is a call; FS1 pushes callPCID_o
//   callPCID_o       return address of that call (slot PC + 8)
//   flagRtrID_o      redirecting slot is a return; FS1 restores its RAS
//   valid_o          bundle valid to decode
//   instValid_o      per-slot valid; slots after the redirect/taken slot are 0
//   bundle_o         registered bundle
//   pc_o             registered bundle PC
// ---------------------------------------------------------------------------
module fetch_stage2_predecode #(
    parameter int SIZE_PC = 32,
    parameter int INST_W  = 64,
    parameter int OPC_LSB = 32,
    parameter int RA_REG  = 31
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic                 stall_i,
    input  logic                 fs1Ready_i,
    input  logic [SIZE_PC-1:0]   pc_i,
    input  logic [4*INST_W-1:0]  bundle_i,
    input  logic [3:0]           btbHit_i,
    input  logic [4*SIZE_PC-1:0] btbTarget_i,
    input  logic [3:0]           pred_i,
    input  logic [SIZE_PC-1:0]   rasTop_i,
    output logic                 flagRecoverID_o,
    output logic [SIZE_PC-1:0]   targetAddrID_o,
    output logic                 flagCallID_o,
    output logic [SIZE_PC-1:0]   callPCID_o,
    output logic                 flagRtrID_o,
    output logic                 valid_o,
    output logic [3:0]           instValid_o,
    output logic [4*INST_W-1:0]  bundle_o,
    output logic [SIZE_PC-1:0]   pc_o
);

    localparam logic [7:0] OP_J     = 8'h01;
    localparam logic [7:0] OP_JAL   = 8'h02;
    localparam logic [7:0] OP_JR    = 8'h03;
    localparam logic [7:0] OP_JALR  = 8'h04;
    localparam logic [7:0] OP_BR_LO = 8'h05;
    localparam logic [7:0] OP_BR_HI = 8'h0A;
    localparam logic [7:0] RA_NUM   = 8'(RA_REG);

    typedef enum logic {
        IDLE,
        RECOVERED
    } state_t;

    state_t state;
    state_t state_next;

    // Stage registers
    logic                 valid_q;
    logic [SIZE_PC-1:0]   pc_q;
    logic [4*INST_W-1:0]  bundle_q;
    logic [3:0]           hit_q;
    logic [3:0]           pred_q;
    logic [4*SIZE_PC-1:0] btb_target_q;
    logic [SIZE_PC-1:0]   ras_top_q;

    // Per-slot predecode results
    logic [7:0]         slot_opc  [4];
    logic [7:0]         slot_rs   [4];
    logic [25:0]        slot_imm  [4];
    logic [SIZE_PC-1:0] slot_pc   [4];
    logic [SIZE_PC-1:0] slot_seq  [4];
    logic [SIZE_PC-1:0] slot_dest [4];
    logic [SIZE_PC-1:0] slot_btb  [4];
    logic [3:0]         is_jump;
    logic [3:0]         is_call;
    logic [3:0]         is_ret;
    logic [3:0]         is_cond;
    logic [3:0]         is_direct;
    logic [3:0]         is_cti;

    // Redirect selection
    logic               taken_found;
    logic [1:0]         taken_slot;
    logic [1:0]         scan_last;
    logic               miss_found;
    logic [1:0]         miss_slot;
    logic               redirect_found;
    logic [1:0]         redirect_slot;
    logic [SIZE_PC-1:0] redirect_target;
    logic [1:0]         last_valid;
    logic               flag_recover;

    // Slot decode. A return's "decoded" target is the RAS top captured with the
    // bundle; J/JAL use the region-relative form and branches are PC-relative to
    // the following slot.
    always_comb begin
        slot_opc  = '{default: '0};
        slot_rs   = '{default: '0};
        slot_imm  = '{default: '0};
        slot_pc   = '{default: '0};
        slot_seq  = '{default: '0};
        slot_dest = '{default: '0};
        slot_btb  = '{default: '0};
        is_jump   = '0;
        is_call   = '0;
        is_ret    = '0;
        is_cond   = '0;
        is_direct = '0;
        is_cti    = '0;
        for (int i = 0; i < 4; i++) begin
            slot_opc[i] = bundle_q[i*INST_W+OPC_LSB +: 8];
            slot_rs[i]  = bundle_q[i*INST_W+24 +: 8];
            slot_imm[i] = bundle_q[i*INST_W +: 26];
            slot_pc[i]  = pc_q + SIZE_PC'(8 * i);
            slot_seq[i] = slot_pc[i] + SIZE_PC'(8);
            slot_btb[i] = btb_target_q[i*SIZE_PC +: SIZE_PC];

            is_jump[i]   = (slot_opc[i] == OP_J) | (slot_opc[i] == OP_JAL);
            is_call[i]   = (slot_opc[i] == OP_JAL) | (slot_opc[i] == OP_JALR);
            is_ret[i]    = (slot_opc[i] == OP_JR) & (slot_rs[i] == RA_NUM);
            is_cond[i]   = (slot_opc[i] >= OP_BR_LO) & (slot_opc[i] <= OP_BR_HI);
            is_direct[i] = is_jump[i] | is_cond[i];
            is_cti[i]    = (slot_opc[i] >= OP_J) & (slot_opc[i] <= OP_BR_HI);

            if (is_ret[i]) begin
                slot_dest[i] = ras_top_q;
            end else if (is_cond[i]) begin
                slot_dest[i] = slot_seq[i] +
                               {{(SIZE_PC-18){slot_imm[i][15]}}, slot_imm[i][15:0], 2'b00};
            end else begin
                slot_dest[i] = {slot_pc[i][SIZE_PC-1:28], slot_imm[i], 2'b00};
            end
        end
    end

    // Redirect priority: an unpredicted J/JAL/return at or before the taken
    // slot wins; otherwise a wrong BTB target on a direct taken CTI; otherwise
    // a BTB hit on something that is not a CTI at all (phantom branch).
    // The descending loops leave the lowest qualifying slot selected.
    always_comb begin
        taken_found = 1'b0;
        taken_slot  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (hit_q[i] & (pred_q[i] | ~is_cond[i])) begin
                taken_found = 1'b1;
                taken_slot  = 2'(i);
            end
        end

        scan_last  = taken_found ? taken_slot : 2'd3;
        miss_found = 1'b0;
        miss_slot  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if ((2'(i) <= scan_last) & (is_jump[i] | is_ret[i]) & ~hit_q[i]) begin
                miss_found = 1'b1;
                miss_slot  = 2'(i);
            end
        end

        redirect_found  = 1'b0;
        redirect_slot   = 2'd0;
        redirect_target = '0;
        if (miss_found) begin
            redirect_found  = 1'b1;
            redirect_slot   = miss_slot;
            redirect_target = slot_dest[miss_slot];
        end else if (taken_found & is_direct[taken_slot] &
                     (slot_btb[taken_slot] != slot_dest[taken_slot])) begin
            redirect_found  = 1'b1;
            redirect_slot   = taken_slot;
            redirect_target = slot_dest[taken_slot];
        end else if (taken_found & ~is_cti[taken_slot]) begin
            redirect_found  = 1'b1;
            redirect_slot   = taken_slot;
            redirect_target = slot_seq[taken_slot];
        end
    end

    // Outputs. The pulse is suppressed once it has been seen for a held
    // bundle, but the slot mask still reflects where the bundle really ends.
    always_comb begin
        flag_recover = valid_q & redirect_found & (state == IDLE);
        last_valid   = redirect_found ? redirect_slot :
                       (taken_found ? taken_slot : 2'd3);

        flagRecoverID_o = flag_recover;
        targetAddrID_o  = flag_recover ? redirect_target : '0;
        flagCallID_o    = flag_recover & is_call[redirect_slot];
        callPCID_o      = (flag_recover & is_call[redirect_slot]) ? slot_seq[redirect_slot] : '0;
        flagRtrID_o     = flag_recover & is_ret[redirect_slot];
        valid_o         = valid_q;
        bundle_o        = bundle_q;
        pc_o            = pc_q;
        instValid_o     = '0;
        for (int i = 0; i < 4; i++) begin
            instValid_o[i] = valid_q & (2'(i) <= last_valid);
        end
    end

    // Redirect FSM next state: remember that the held bundle already
    // redirected so a long stall does not repeat the pulse.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (flag_recover & stall_i & ~flush_i) begin
                    state_next = RECOVERED;
                end
            end
            RECOVERED: begin
                if (flush_i | ~stall_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage registers. While redirecting without a stall, the bundle FS1 is
    // presenting is wrong-path, so it is captured but marked invalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            valid_q      <= 1'b0;
            pc_q         <= '0;
            bundle_q     <= '0;
            hit_q        <= '0;
            pred_q       <= '0;
            btb_target_q <= '0;
            ras_top_q    <= '0;
        end else begin
            state <= state_next;
            if (!stall_i) begin
                valid_q      <= fs1Ready_i & ~flush_i & ~flag_recover;
                pc_q         <= pc_i;
                bundle_q     <= bundle_i;
                hit_q        <= btbHit_i;
                pred_q       <= pred_i;
                btb_target_q <= btbTarget_i;
                ras_top_q    <= rasTop_i;
            end else if (flush_i) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage2_predecode.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage2_predecode
//
// Testbench for fetch_stage2_predecode. It runs a sequence of directed
// scenarios followed by random traffic. Every cycle it compares the design's
// outputs with a reference model that derives the expected redirect from the
// predecode rules applied to the bundle held in the stage.
// ---------------------------------------------------------------------------
module tb_fetch_stage2_predecode;

    localparam int K_OTHER = 0;
    localparam int K_J     = 1;
    localparam int K_JAL   = 2;
    localparam int K_RET   = 3;
    localparam int K_JR    = 4;
    localparam int K_JALR  = 5;
    localparam int K_COND  = 6;

    typedef struct packed {
        logic         valid;
        logic [31:0]  pc;
        logic [255:0] bundle;
        logic [3:0]   hit;
        logic [127:0] tgt;
        logic [3:0]   pred;
        logic [31:0]  ras;
    } stage_t;

    typedef struct packed {
        logic        flag;
        logic [31:0] target;
        logic        call;
        logic [31:0] callPc;
        logic        rtr;
        logic [3:0]  iv;
    } expect_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         stall;
    logic         fs1Ready;
    logic [31:0]  pcIn;
    logic [255:0] bundleIn;
    logic [3:0]   btbHit;
    logic [127:0] btbTarget;
    logic [3:0]   pred;
    logic [31:0]  rasTop;
    logic         flagRecover;
    logic [31:0]  targetAddr;
    logic         flagCall;
    logic [31:0]  callPc;
    logic         flagRtr;
    logic         validOut;
    logic [3:0]   instValid;
    logic [255:0] bundleOut;
    logic [31:0]  pcOut;

    stage_t model;
    logic   modelDone;
    int     nAssert = 0;
    int     nFail = 0;

    fetch_stage2_predecode dut (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (flush),
        .stall_i        (stall),
        .fs1Ready_i     (fs1Ready),
        .pc_i           (pcIn),
        .bundle_i       (bundleIn),
        .btbHit_i       (btbHit),
        .btbTarget_i    (btbTarget),
        .pred_i         (pred),
        .rasTop_i       (rasTop),
        .flagRecoverID_o(flagRecover),
        .targetAddrID_o (targetAddr),
        .flagCallID_o   (flagCall),
        .callPCID_o     (callPc),
        .flagRtrID_o    (flagRtr),
        .valid_o        (validOut),
        .instValid_o    (instValid),
        .bundle_o       (bundleOut),
        .pc_o           (pcOut)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [63:0] mkInst(logic [7:0] op, logic [31:0] low);
        return {24'h0, op, low};
    endfunction

    function automatic int slotKind(logic [63:0] inst);
        logic [7:0] op;
        op = inst[39:32];
        if (op == 8'h01) return K_J;
        if (op == 8'h02) return K_JAL;
        if (op == 8'h03) return (inst[31:24] == 8'd31) ? K_RET : K_JR;
        if (op == 8'h04) return K_JALR;
        if (op >= 8'h05 && op <= 8'h0A) return K_COND;
        return K_OTHER;
    endfunction

    function automatic logic [31:0] slotDest(logic [63:0] inst, logic [31:0] spc, logic [31:0] ras);
        int          kind;
        logic [31:0] off;
        kind = slotKind(inst);
        if (kind == K_J || kind == K_JAL) return (spc & 32'hF000_0000) | (32'(inst[25:0]) * 4);
        if (kind == K_RET) return ras;
        if (kind == K_COND) begin
            off = {{16{inst[15]}}, inst[15:0]};
            return spc + 32'd8 + off * 4;
        end
        return 32'h0;
    endfunction

    // Reference model: expected redirect/mask for the stage contents
    function automatic expect_t predict(stage_t s, logic done);
        expect_t     e;
        int          kind [4];
        logic [31:0] spc  [4];
        logic [31:0] dest [4];
        int          k;
        int          r;
        int          last;
        logic [31:0] redirTgt;
        e = '0;
        k = -1;
        r = -1;
        redirTgt = 32'h0;
        for (int i = 0; i < 4; i++) begin
            spc[i]  = s.pc + 32'(8 * i);
            kind[i] = slotKind(s.bundle[64*i +: 64]);
            dest[i] = slotDest(s.bundle[64*i +: 64], spc[i], s.ras);
        end
        for (int i = 0; i < 4; i++) begin
            if (s.hit[i] && (s.pred[i] || kind[i] != K_COND)) begin
                k = i;
                break;
            end
        end
        for (int j = 0; j <= ((k < 0) ? 3 : k); j++) begin
            if ((kind[j] == K_J || kind[j] == K_JAL || kind[j] == K_RET) && !s.hit[j]) begin
                r = j;
                redirTgt = dest[j];
                break;
            end
        end
        if (r < 0 && k >= 0) begin
            if ((kind[k] == K_J || kind[k] == K_JAL || kind[k] == K_COND) &&
                s.tgt[32*k +: 32] != dest[k]) begin
                r = k;
                redirTgt = dest[k];
            end else if (kind[k] == K_OTHER) begin
                r = k;
                redirTgt = spc[k] + 32'd8;
            end
        end
        last = (r >= 0) ? r : ((k >= 0) ? k : 3);
        if (s.valid) e.iv = 4'((1 << (last + 1)) - 1);
        if (s.valid && r >= 0 && !done) begin
            e.flag   = 1'b1;
            e.target = redirTgt;
            e.call   = (kind[r] == K_JAL || kind[r] == K_JALR);
            e.rtr    = (kind[r] == K_RET);
            if (e.call) e.callPc = spc[r] + 32'd8;
        end
        return e;
    endfunction

    task automatic checkEq(string tag, logic [255:0] obs, logic [255:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(string tag);
        expect_t e;
        e = predict(model, modelDone);
        checkEq({tag, ".valid"},     256'(validOut),    256'(model.valid));
        checkEq({tag, ".instValid"}, 256'(instValid),   256'(e.iv));
        checkEq({tag, ".flag"},      256'(flagRecover), 256'(e.flag));
        checkEq({tag, ".target"},    256'(targetAddr),  256'(e.target));
        checkEq({tag, ".call"},      256'(flagCall),    256'(e.call));
        checkEq({tag, ".callPc"},    256'(callPc),      256'(e.callPc));
        checkEq({tag, ".rtr"},       256'(flagRtr),     256'(e.rtr));
        checkEq({tag, ".pc"},        256'(pcOut),       256'(model.pc));
        checkEq({tag, ".bundle"},    bundleOut,         model.bundle);
    endtask

    task automatic applyStimulus(logic rdy, logic fl, logic st, logic [31:0] pcV,
                                 logic [255:0] bV, logic [3:0] hitV, logic [127:0] tgtV,
                                 logic [3:0] predV, logic [31:0] rasV);
        fs1Ready  = rdy;
        flush     = fl;
        stall     = st;
        pcIn      = pcV;
        bundleIn  = bV;
        btbHit    = hitV;
        btbTarget = tgtV;
        pred      = predV;
        rasTop    = rasV;
    endtask

    // Advance one clock, updating the model with the inputs seen at the edge
    task automatic tick();
        expect_t pre;
        pre = predict(model, modelDone);
        @(posedge clk);
        if (!reset) begin
            model     = '0;
            modelDone = 1'b0;
        end else begin
            if (flush || !stall) modelDone = 1'b0;
            else if (pre.flag) modelDone = 1'b1;
            if (!stall) begin
                model.valid  = fs1Ready & ~flush & ~pre.flag;
                model.pc     = pcIn;
                model.bundle = bundleIn;
                model.hit    = btbHit;
                model.tgt    = btbTarget;
                model.pred   = pred;
                model.ras    = rasTop;
            end else if (flush) begin
                model.valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 256'h0, 4'h0, 128'h0, 4'h0, 32'h0);
        tick();
    endtask

    function automatic logic [63:0] randInst();
        logic [63:0] inst;
        int          sel;
        inst = {$urandom, $urandom};
        sel  = $urandom_range(0, 9);
        case (sel)
            0, 1, 2: inst[39:32] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(11, 255));
            3: inst[39:32] = 8'h01;
            4: inst[39:32] = 8'h02;
            5: begin
                inst[39:32] = 8'h03;
                inst[31:24] = 8'd31;
            end
            6: begin
                inst[39:32] = 8'h03;
                inst[31:24] = 8'($urandom_range(0, 30));
            end
            7: inst[39:32] = 8'h04;
            default: inst[39:32] = 8'($urandom_range(5, 10));
        endcase
        return inst;
    endfunction

    initial begin
        logic [255:0] bv;
        logic [127:0] tv;
        logic [31:0]  pcR;
        logic [31:0]  rasR;
        logic [3:0]   hitR;
        int           pulses;

        $display("[TB] fetch_stage2_predecode test start");
        model     = '0;
        modelDone = 1'b0;
        reset     = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 256'h0, 4'h0, 128'h0, 4'h0, 32'h0);
        tick();
        tick();
        checkOutput("reset");
        checkEq("reset.validConst", 256'(validOut), 256'(0));
        reset = 1'b1;

        // Slot 1 J missed by the BTB
        bv = '0;
        bv[127:64] = mkInst(8'h01, 32'h400);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h1000, bv, 4'h0, 128'h0, 4'h0, 32'h0);
        tick();
        checkOutput("jMiss");
        checkEq("jMiss.flagConst", 256'(flagRecover), 256'(1));
        checkEq("jMiss.targetConst", 256'(targetAddr), 256'(32'h1000));
        checkEq("jMiss.ivConst", 256'(instValid), 256'(4'b0011));
        // Next FS1 bundle is wrong-path and must be dropped
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h1100, 256'h0, 4'h0, 128'h0, 4'h0, 32'h0);
        tick();
        checkOutput("wrongPath");
        checkEq("wrongPath.validConst", 256'(validOut), 256'(0));

        // Slot 2 BEQ with a wrong BTB target
        idle();
        bv = '0;
        bv[191:128] = mkInst(8'h05, 32'h10);
        tv = '0;
        tv[95:64] = 32'h3000;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h2000, bv, 4'b0100, tv, 4'b0100, 32'h0);
        tick();
        checkOutput("beq");
        checkEq("beq.targetConst", 256'(targetAddr), 256'(32'h2058));
        checkEq("beq.ivConst", 256'(instValid), 256'(4'b0111));

        // Slot 0 JAL missed: call with return address
        idle();
        bv = '0;
        bv[63:0] = mkInst(8'h02, 32'h100);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h4000, bv, 4'h0, 128'h0, 4'h0, 32'h0);
        tick();
        checkOutput("jal");
        checkEq("jal.callConst", 256'(flagCall), 256'(1));
        checkEq("jal.callPcConst", 256'(callPc), 256'(32'h4008));

        // Slot 3 JR $31 missed: return through the RAS
        idle();
        bv = '0;
        bv[255:192] = mkInst(8'h03, 32'h1F00_0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h4000, bv, 4'h0, 128'h0, 4'h0, 32'h5554);
        tick();
        checkOutput("ret");
        checkEq("ret.rtrConst", 256'(flagRtr), 256'(1));
        checkEq("ret.targetConst", 256'(targetAddr), 256'(32'h5554));

        // Redirect held under a 3-cycle stall: exactly one pulse
        idle();
        bv = '0;
        bv[127:64] = mkInst(8'h01, 32'h400);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h1000, bv, 4'h0, 128'h0, 4'h0, 32'h0);
        tick();
        checkOutput("stall0");
        pulses = flagRecover ? 1 : 0;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h9000, 256'h0, 4'h0, 128'h0, 4'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("stallHold");
            checkEq("stallHold.pcConst", 256'(pcOut), 256'(32'h1000));
            if (flagRecover) pulses++;
        end
        checkEq("stall.pulses", 256'(pulses), 256'(1));
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h9000, 256'h0, 4'h0, 128'h0, 4'h0, 32'h0);
        tick();
        checkOutput("stallRelease");
        checkEq("stallRelease.validConst", 256'(validOut), 256'(1));

        // Flush with stall, then flush racing a valid FS1 bundle
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hA000, 256'h0, 4'h0, 128'h0, 4'h0, 32'h0);
        tick();
        checkOutput("flushStall");
        checkEq("flushStall.validConst", 256'(validOut), 256'(0));
        applyStimulus(1'b1, 1'b1, 1'b0, 32'hA000, 256'h0, 4'h0, 128'h0, 4'h0, 32'h0);
        tick();
        checkOutput("flushLoad");
        checkEq("flushLoad.validConst", 256'(validOut), 256'(0));
        applyStimulus(1'b1, 1'b0, 1'b0, 32'hA000, 256'h0, 4'h0, 128'h0, 4'h0, 32'h0);
        tick();
        checkOutput("afterFlush");

        // Asynchronous reset in the middle of a redirecting bundle
        idle();
        bv = '0;
        bv[127:64] = mkInst(8'h01, 32'h400);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h1000, bv, 4'h0, 128'h0, 4'h0, 32'h0);
        tick();
        checkOutput("preReset");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1000, bv, 4'h0, 128'h0, 4'h0, 32'h0);
        #2 reset = 1'b0;
        #1;
        model     = '0;
        modelDone = 1'b0;
        checkOutput("rstAsync");
        checkEq("rstAsync.validConst", 256'(validOut), 256'(0));
        checkEq("rstAsync.flagConst", 256'(flagRecover), 256'(0));
        tick();
        reset = 1'b1;
        tick();
        checkOutput("rstRelease");
        checkEq("rstRelease.flagConst", 256'(flagRecover), 256'(0));

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            pcR  = $urandom & 32'hFFFF_FFF8;
            rasR = $urandom;
            bv   = '0;
            tv   = '0;
            for (int i = 0; i < 4; i++) begin
                bv[64*i +: 64] = randInst();
                hitR[i] = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 1) == 0)
                    tv[32*i +: 32] = slotDest(bv[64*i +: 64], pcR + 32'(8 * i), rasR);
                else
                    tv[32*i +: 32] = $urandom;
            end
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 3) == 0, pcR, bv, hitR, tv,
                          4'($urandom_range(0, 15)), rasR);
            tick();
            checkOutput("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
